// File: rtl/keypad_scanner.sv
// keypad_scanner: self-scanning matrix keypad with two-flop row synchroniser, press/release
// debounce and ghost rejection. Define KEYPAD_TYPEMATIC_EN to enable auto-repeat while held.
module keypad_scanner #(
  parameter int unsigned ROWS          = 4,
  parameter int unsigned COLS          = 4,
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned DEBOUNCE      = 50000,
  parameter int unsigned REPEAT_DELAY  = 25'd24_000_000,
  parameter int unsigned REPEAT_PERIOD = 25'd6_000_000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [ROWS-1:0]                 row_in,
  output logic [COLS-1:0]                 col_out,
  output logic [$clog2(ROWS*COLS)-1:0]    key_code,
  output logic                            key_valid,
  output logic                            key_down
);

  localparam int KW  = $clog2(ROWS*COLS);
  localparam int CW  = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int DWW = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] ST_SCAN       = 2'd0;
  localparam logic [1:0] ST_DB_PRESS   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_DB_RELEASE = 2'd3;

  logic [ROWS-1:0] rowMeta_q, rs_q;
  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   colIdx_q, colIdx_d, colNext;
  logic [DWW-1:0]  dwell_q, dwell_d;
  logic [DBW-1:0]  cnt_q, cnt_d;
  logic [ROWS-1:0] mask_q, mask_d;
  logic [KW-1:0]   code_q, code_d, codeNow;
  logic            valid_q, valid_d;
  logic            down_q, down_d;
  logic [RW-1:0]   rowIdx;
  logic            oneHot;
  logic            keyPresent;

`ifdef KEYPAD_TYPEMATIC_EN
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          repeating_q, repeating_d;
`endif

  assign oneHot     = (rs_q != '0) && ((rs_q & (rs_q - 1'b1)) == '0);
  assign keyPresent = (rs_q & mask_q) != '0;
  assign colNext    = (colIdx_q == CW'(COLS - 1)) ? '0 : colIdx_q + 1'b1;

  always_comb begin
    rowIdx = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (mask_q[r]) rowIdx = RW'(r);
    end
  end

  assign codeNow = KW'(int'(rowIdx) * COLS + int'(colIdx_q));

  always_comb begin
    col_out           = '0;
    col_out[colIdx_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    colIdx_d = colIdx_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    down_d   = down_q;
`ifdef KEYPAD_TYPEMATIC_EN
    hold_d      = hold_q;
    repeating_d = repeating_q;
`endif
    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWW'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          // Zero or multiple rows (ghosting) are simply skipped.
          if (oneHot) begin
            mask_d  = rs_q;
            cnt_d   = '0;
            state_d = ST_DB_PRESS;
          end else begin
            colIdx_d = colNext;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_DB_PRESS: begin
        if (rs_q == mask_q) begin
          if (cnt_q == DBW'(DEBOUNCE - 1)) begin
            state_d = ST_HELD;
            cnt_d   = '0;
            code_d  = codeNow;
            valid_d = 1'b1;
            down_d  = 1'b1;
`ifdef KEYPAD_TYPEMATIC_EN
            hold_d      = '0;
            repeating_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d  = ST_SCAN;
          cnt_d    = '0;
          dwell_d  = '0;
          colIdx_d = colNext;
        end
      end
      ST_HELD: begin
        if (!keyPresent) begin
          // The cycle that first sees the release already counts towards the debounce.
          if (DEBOUNCE == 1) begin
            state_d  = ST_SCAN;
            down_d   = 1'b0;
            cnt_d    = '0;
            dwell_d  = '0;
            colIdx_d = colNext;
          end else begin
            state_d = ST_DB_RELEASE;
            cnt_d   = DBW'(1);
          end
        end else begin
`ifdef KEYPAD_TYPEMATIC_EN
          if (!repeating_q) begin
            if (hold_q == HW'(REPEAT_DELAY - 1)) begin
              valid_d     = 1'b1;
              repeating_d = 1'b1;
              hold_d      = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end else if (hold_q == HW'(REPEAT_PERIOD - 1)) begin
            valid_d = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
`endif
        end
      end
      default: begin
        if (keyPresent) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DBW'(DEBOUNCE - 1)) begin
          state_d  = ST_SCAN;
          down_d   = 1'b0;
          cnt_d    = '0;
          dwell_d  = '0;
          colIdx_d = colNext;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rowMeta_q <= '0;
      rs_q      <= '0;
      state_q   <= ST_SCAN;
      colIdx_q  <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      rowMeta_q <= row_in;
      rs_q      <= rowMeta_q;
      state_q   <= state_d;
      colIdx_q  <= colIdx_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      down_q    <= down_d;
    end
  end

`ifdef KEYPAD_TYPEMATIC_EN
  // Hold counter only advances in HELD, so a release glitch pauses it without reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= '0;
      repeating_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      repeating_q <= repeating_d;
    end
  end
`endif

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios against a per-cycle behavioural model of
// key events, plus hand-computed literal checks on codes, pulse counts and latencies.
module tb_keypad_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;
  localparam int REPEAT_DELAY = 20;
  localparam int REPEAT_PERIOD = 6;
`ifdef KEYPAD_TYPEMATIC_EN
  localparam bit TYPEMATIC = 1'b1;
`else
  localparam bit TYPEMATIC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] col_out;
  logic [3:0] key_code;
  logic key_valid;
  logic key_down;
  logic [15:0] keys = '0;

  int vectors = 0;
  int miscompares = 0;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key connects its column drive onto its row line.
  always_comb begin
    row_in = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS + c] && col_out[c]) row_in[r] = 1'b1;
  end

  typedef enum int {PH_SCAN, PH_CONFIRM, PH_HOLD} phase_t;
  phase_t mPhase;
  logic [3:0] mS1, mRs, mMask;
  int mCol, mDwell, mRun, mRel, mAge, mCode;
  bit mValid, mDown;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = PH_SCAN; mS1 = '0; mRs = '0; mMask = '0;
    mCol = 0; mDwell = 0; mRun = 0; mRel = 0; mAge = 0; mCode = 0;
    mValid = 0; mDown = 0;
  endtask

  function automatic int maskRow(input logic [3:0] m);
    int idx = 0;
    for (int r = 0; r < ROWS; r++) if (m[r]) idx = r;
    return idx;
  endfunction

  // Advance the model across one clock edge, given the row lines presented before that edge.
  task automatic modelStep(input logic [3:0] rowNow);
    mValid = 0;
    case (mPhase)
      PH_SCAN: begin
        mDwell++;
        if (mDwell == SCAN_DIV) begin
          mDwell = 0;
          if ($countones(mRs) == 1) begin
            mMask = mRs; mRun = 0; mPhase = PH_CONFIRM;
          end else mCol = (mCol + 1) % COLS;
        end
      end
      PH_CONFIRM: begin
        if (mRs == mMask) begin
          mRun++;
          if (mRun == DEBOUNCE) begin
            mPhase = PH_HOLD; mCode = maskRow(mMask) * COLS + mCol;
            mValid = 1; mDown = 1; mAge = 0; mRel = 0;
          end
        end else begin
          mPhase = PH_SCAN; mCol = (mCol + 1) % COLS; mDwell = 0;
        end
      end
      default: begin
        if ((mRs & mMask) != 0) begin
          if (mRel == 0) begin
            mAge++;
            if (TYPEMATIC && mAge >= REPEAT_DELAY && (mAge - REPEAT_DELAY) % REPEAT_PERIOD == 0)
              mValid = 1;
          end
          mRel = 0;
        end else begin
          mRel++;
          if (mRel == DEBOUNCE) begin
            mPhase = PH_SCAN; mDown = 0; mCol = (mCol + 1) % COLS; mDwell = 0;
          end
        end
      end
    endcase
    mRs = mS1;
    mS1 = rowNow;
  endtask

  // Every cycle: DUT outputs must match the model, then the model steps.
  initial begin
    logic [9:0] expv;
    modelReset();
    forever begin
      @(negedge clk);
      if (!reset_n) modelReset();
      expv = {4'(1 << mCol), 4'(mCode), mValid, mDown};
      checkOutput("cycle", {22'd0, col_out, key_code, key_valid, key_down}, {22'd0, expv});
      if (reset_n) modelStep(row_in);
    end
  end

  task automatic applyStimulus(input logic [15:0] v);
    @(posedge clk);
    #1 keys = v;
  endtask

  task automatic runCycles(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
  endtask

  task automatic waitAccept(input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (key_valid) found = 1;
    end
  endtask

  initial begin
    int p;
    bit found;
    bit allDown;
    bit sawCol0;
    int offs[$];

    repeat (3) @(negedge clk);
    checkOutput("resetCol", {28'd0, col_out}, 32'h1);
    checkOutput("resetCode", {28'd0, key_code}, 32'h0);
    checkOutput("resetValid", {31'd0, key_valid}, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      checkOutput("colStep", {28'd0, col_out}, 32'(1 << ((k / 4) % 4)));
    end

    // Clean press row 2, col 1.
    applyStimulus(16'h1 << 9);
    waitAccept(60, found);
    checkOutput("cleanAccept", {31'd0, found}, 32'd1);
    checkOutput("cleanCode", {28'd0, key_code}, 32'd9);
    runCycles(15, p);
    checkOutput("cleanSingle", p, 32'd0);
    checkOutput("cleanDown", {31'd0, key_down}, 32'd1);
    applyStimulus(16'h0);
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      if (j == 9) checkOutput("relStillDown", {31'd0, key_down}, 32'd1);
      if (j == 10) checkOutput("relDownFall", {31'd0, key_down}, 32'd0);
    end
    checkOutput("codeKept", {28'd0, key_code}, 32'd9);
    runCycles(10, p);

    // Bouncing press on row 1, col 3.
    p = 0;
    for (int i = 0; i < 7; i++) begin
      int q;
      applyStimulus(keys ^ (16'h1 << 7));
      runCycles(3, q);
      p += q;
    end
    checkOutput("bounceQuiet", p, 32'd0);
    waitAccept(60, found);
    checkOutput("bounceAccept", {31'd0, found}, 32'd1);
    checkOutput("bounceCode", {28'd0, key_code}, 32'd7);
    runCycles(10, p);
    checkOutput("bounceSingle", p, 32'd0);
    applyStimulus(16'h0);
    runCycles(20, p);

    // Ghost: rows 0 and 3 on column 2.
    applyStimulus((16'h1 << 2) | (16'h1 << 14));
    p = 0; sawCol0 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_valid) p++;
      if (col_out == 4'b0001) sawCol0 = 1;
    end
    checkOutput("ghostQuiet", p, 32'd0);
    checkOutput("ghostScanning", {31'd0, sawCol0}, 32'd1);
    applyStimulus(16'h1 << 2);
    waitAccept(60, found);
    checkOutput("ghostAccept", {31'd0, found}, 32'd1);
    checkOutput("ghostCode", {28'd0, key_code}, 32'd2);
    applyStimulus(16'h0);
    runCycles(20, p);

    // Release glitch while held, row 1 col 1.
    applyStimulus(16'h1 << 5);
    waitAccept(60, found);
    checkOutput("glitchAccept", {31'd0, found}, 32'd1);
    allDown = 1;
    runCycles(4, p);
    applyStimulus(16'h0);
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (!key_down) allDown = 0; if (key_valid) p++; end
    applyStimulus(16'h1 << 5);
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (!key_down) allDown = 0; if (key_valid) p++; end
    checkOutput("glitchHeld", {31'd0, allDown}, 32'd1);
    checkOutput("glitchNoRepeat", p, 32'd0);
    applyStimulus(16'h0);
    runCycles(12, p);
    checkOutput("glitchReleased", {31'd0, key_down}, 32'd0);

    // Reset in the middle of press debounce on column 2.
    applyStimulus(16'h1 << 6);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mPhase == PH_CONFIRM) found = 1;
    end
    checkOutput("reachConfirm", {31'd0, found}, 32'd1);
    runCycles(2, p);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midResetCol", {28'd0, col_out}, 32'h1);
    checkOutput("midResetCode", {28'd0, key_code}, 32'h0);
    checkOutput("midResetFlags", {30'd0, key_valid, key_down}, 32'h0);
    keys = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    runCycles(5, p);

    // Long hold on row 2, col 2: auto-repeat only when typematic is built in.
    applyStimulus(16'h1 << 10);
    waitAccept(60, found);
    checkOutput("holdAccept", {31'd0, found}, 32'd1);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (key_valid) offs.push_back(k);
    end
    checkOutput("repeatCount", offs.size(), TYPEMATIC ? 32'd6 : 32'd0);
    for (int i = 0; i < offs.size(); i++)
      checkOutput("repeatOffset", offs[i], 32'(REPEAT_DELAY + REPEAT_PERIOD * i));
    checkOutput("holdCode", {28'd0, key_code}, 32'd10);
    applyStimulus(16'h0);
    runCycles(15, p);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner and decoder. Drives one column at a time and samples the row lines through a two-flop synchroniser. Debounces both press and release, rejects multi-key (ghost) readings, and emits a binary key code with a one-cycle valid strobe. It sits between the keypad pins and the display/digit-storage logic, and replaces static one-hot-to-hex decoding with a self-scanning, debounced source of key events.

## Interface
- ROWS, 4: number of row inputs (≥2).
- COLS, 4: number of column outputs (≥2).
- SCAN_DIV, 1000: clk cycles each column is driven while scanning (≥2).
- DEBOUNCE, 50000: consecutive stable cycles required to accept a press or a release (≥1).
- REPEAT_DELAY, 25'd24_000_000: cycles held before the first auto-repeat (used only with KEYPAD_TYPEMATIC_EN).
- REPEAT_PERIOD, 25'd6_000_000: cycles between auto-repeats (used only with KEYPAD_TYPEMATIC_EN).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- row_in  in  ROWS  raw row lines, active-high, asynchronous to clk.
- col_out  out  COLS  one-hot active-high column drive.
- key_code  out  $clog2(ROWS*COLS)  code of the last accepted key, computed as row_idx*COLS + col_idx.
- key_valid  out  1  one-cycle strobe when key_code is newly accepted.
- key_down  out  1  level; high while an accepted key is held.

## Operation
- Synchroniser: row_in passes through 2 flops; all logic uses the synchronised value rs. rs resets to 0.
- SCAN:
  - col_idx dwells SCAN_DIV cycles per column, then advances, wrapping COLS-1 → 0.
  - rs is evaluated only on the last dwell cycle of each column.
  - rs exactly one-hot: latch row mask and col_idx, freeze the column, go to DB_PRESS.
  - rs zero or more than one bit set (ghost or multi-key): no action; scanning continues.
- DB_PRESS:
  - The counter increments each cycle that rs equals the latched mask.
  - Any mismatch: return to SCAN, clear the counter, advance the column.
  - Counter reaches DEBOUNCE: go to HELD. On the same edge, load key_code, pulse key_valid, and set key_down=1.
- HELD:
  - Column stays frozen.
  - Extra row bits appearing in rs are ignored.
  - (rs & mask)==0: go to DB_RELEASE.
- DB_RELEASE:
  - Latched bit reasserts: return to HELD. No key_valid is issued.
  - Released for DEBOUNCE consecutive cycles: clear key_down, advance the column, go to SCAN.
- key_code holds its value after release until the next accepted press.
- Reset mid-operation (any state): immediately return to SCAN with col_idx=0. key_valid=0 and key_down=0. Any pending debounce is discarded.
- All counters are saturating or cleared on state entry; none may wrap into a false accept.

## Timing
- Reset values: col_out=1 (column 0), key_code=0, key_valid=0, key_down=0, state SCAN, all counters 0.
- Input latency: a row_in change is visible in rs 2 cycles later.
- Press latency: SCAN sample on cycle T → key_valid high on cycle T+DEBOUNCE+1, for exactly 1 cycle. key_code and key_down update on that same edge.
- Release latency: from the first cycle (rs&mask)==0, key_down falls DEBOUNCE cycles later. col_out advances on that same edge.
- col_out changes only on dwell expiry in SCAN, or on exit from DB_PRESS (fail) or DB_RELEASE (complete). It is never all-zero and never multi-hot.
- Worst-case detection of a stable single press: COLS*SCAN_DIV + DEBOUNCE + 3 cycles.

## Configuration
- KEYPAD_TYPEMATIC_EN defined:
  - In HELD, a hold counter starts at 0 on entry.
  - At REPEAT_DELAY it issues a key_valid pulse with key_code unchanged.
  - It then issues a further pulse every REPEAT_PERIOD cycles while held.
  - DB_RELEASE pauses the hold counter. A return to HELD resumes it without reset.
- KEYPAD_TYPEMATIC_EN undefined:
  - Exactly one key_valid per accepted press.
  - No hold counter is synthesised, and the REPEAT_* parameters are unused.

## Test plan
Parameters for all scenarios: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=8, REPEAT_DELAY=20, REPEAT_PERIOD=6.
- Reset release: col_out=4'b0001 and key_valid=0. col_out steps 0001→0010→0100→1000→0001, dwelling 4 cycles each.
- Clean press at row 2, col 1, held 40 cycles: exactly one key_valid, key_code=9, key_down=1; after release plus 8 cycles, key_down=0.
- Bounce on press: row toggles every 3 cycles for 20 cycles, then stable. No key_valid during bounce; exactly one key_valid after 8 stable cycles.
- Ghost: rows 0 and 3 both high on col 2 → no key_valid and scanning continues. Releasing row 3 → key_code=2 is accepted.
- Release glitch: in HELD, row drops for 3 cycles then returns → key_down stays 1 and no second key_valid. reset_n low mid-DB_PRESS → all outputs return to reset values within 1 cycle.
- KEYPAD_TYPEMATIC_EN defined, key held 50 cycles past accept: key_valid pulses at +0, +20, +26, +32, +38, +44, +50 with the same key_code. Undefined: only the +0 pulse.
